sd_cmd_host_regs: RTL and testbench

- Register-side command sequencer sitting directly upstream/downstream of the SD CMD line engine.
- Software programs argument and command registers through a simple register bus; this block launches the command into the CMD engine (new_command, cmd_index, cmd_argument, timeout_enable, no_response).
- It consumes the engine's response and completion via four-phase handshakes, stores the 128-bit response, and raises interrupt status bits.
- It also provides a watchdog in case the engine never completes.

---
 rtl/sd_cmd_host_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_sd_cmd_host_regs.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_host_regs
// Brief    : Register front-end and command sequencer for the SD CMD engine.
// Revision : 1.0 - initial release
// ============================================================================
module sd_cmd_host_regs #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   reg_addr,
    input  logic         reg_wr,
    input  logic [31:0]  reg_wdata,
    output logic [31:0]  reg_rdata,
    output logic         irq,
    output logic         new_command,
    output logic [31:0]  cmd_argument,
    output logic [5:0]   cmd_index,
    output logic         timeout_enable,
    output logic         no_response,
    input  logic [127:0] response,
    input  logic         enable_response,
    output logic         ack_response,
    input  logic         enable_command_complete,
    output logic         ack_command_complete
);

    localparam logic [3:0] c_ADDR_ARG  = 4'd0;
    localparam logic [3:0] c_ADDR_CMD  = 4'd1;
    localparam logic [3:0] c_ADDR_R0   = 4'd2;
    localparam logic [3:0] c_ADDR_R1   = 4'd3;
    localparam logic [3:0] c_ADDR_R2   = 4'd4;
    localparam logic [3:0] c_ADDR_R3   = 4'd5;
    localparam logic [3:0] c_ADDR_ST   = 4'd6;
    localparam logic [3:0] c_ADDR_IST  = 4'd7;
    localparam logic [3:0] c_ADDR_IEN  = 4'd8;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
        S_RESP_ACK = 3'd3,
        S_DONE_ACK = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [31:0]        r_argument;
    logic [9:0]         r_command;
    logic [127:0]       r_resp;
    logic [3:0]         r_int_status;
    logic [3:0]         r_int_enable;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ack_resp;
    logic               r_ack_done;
    logic               r_irq;
    logic [31:0]        r_cmd_arg;
    logic [5:0]         r_cmd_idx;
    logic               r_tmo_en;
    logic               r_no_resp;

    logic               w_wr_arg;
    logic               w_wr_cmd;
    logic               w_wr_ist;
    logic               w_wr_ien;
    logic               w_busy;
    logic               w_launch;
    logic               w_capture;
    logic               w_cnt_clr;
    logic [3:0]         w_set;
    logic [3:0]         w_w1c;

    assign w_wr_arg = reg_wr && (reg_addr == c_ADDR_ARG);
    assign w_wr_cmd = reg_wr && (reg_addr == c_ADDR_CMD);
    assign w_wr_ist = reg_wr && (reg_addr == c_ADDR_IST);
    assign w_wr_ien = reg_wr && (reg_addr == c_ADDR_IEN);
    assign w_busy   = (r_state != S_IDLE);
    assign w_w1c    = w_wr_ist ? reg_wdata[3:0] : 4'b0000;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and per-cycle control
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_capture = 1'b0;
        w_cnt_clr = 1'b0;
        w_set     = 4'b0000;
        w_set[3]  = w_wr_cmd && w_busy;
        case (r_state)
            S_IDLE: begin
                if (w_wr_cmd) begin
                    w_launch = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_clr = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                // Response takes precedence over completion; a response
                // request on a no-response command is never serviced.
                if (enable_response && !r_no_resp) begin
                    w_capture = 1'b1;
                    w_set[1]  = 1'b1;
                    w_next    = S_RESP_ACK;
                end else if (enable_command_complete) begin
                    w_next = S_DONE_ACK;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_set[2] = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            S_RESP_ACK: begin
                if (!enable_response) begin
                    w_cnt_clr = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_DONE_ACK: begin
                if (!enable_command_complete) begin
                    w_set[0] = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers, datapath and handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_argument   <= 32'd0;
            r_command    <= 10'd0;
            r_resp       <= 128'd0;
            r_int_status <= 4'd0;
            r_int_enable <= 4'd0;
            r_cnt        <= '0;
            r_ack_resp   <= 1'b0;
            r_ack_done   <= 1'b0;
            r_irq        <= 1'b0;
            r_cmd_arg    <= 32'd0;
            r_cmd_idx    <= 6'd0;
            r_tmo_en     <= 1'b0;
            r_no_resp    <= 1'b0;
        end else begin
            if (w_wr_arg) begin
                r_argument <= reg_wdata;
            end
            if (w_wr_ien) begin
                r_int_enable <= reg_wdata[3:0];
            end
            if (w_launch) begin
                r_command <= {reg_wdata[9:8], 2'b00, reg_wdata[5:0]};
                r_cmd_idx <= reg_wdata[5:0];
                r_no_resp <= reg_wdata[8];
                r_tmo_en  <= reg_wdata[9];
                r_cmd_arg <= r_argument;
            end
            if (w_capture) begin
                r_resp <= response;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Hardware set is applied after the clear so it wins a collision.
            r_int_status <= (r_int_status & ~w_w1c) | w_set;
            r_irq        <= |(r_int_status & r_int_enable);
            r_ack_resp   <= (w_next == S_RESP_ACK);
            r_ack_done   <= (w_next == S_DONE_ACK);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            c_ADDR_ARG: reg_rdata = r_argument;
            c_ADDR_CMD: reg_rdata = {22'd0, r_command};
            c_ADDR_R0:  reg_rdata = r_resp[31:0];
            c_ADDR_R1:  reg_rdata = r_resp[63:32];
            c_ADDR_R2:  reg_rdata = r_resp[95:64];
            c_ADDR_R3:  reg_rdata = r_resp[127:96];
            c_ADDR_ST:  reg_rdata = {31'd0, w_busy};
            c_ADDR_IST: reg_rdata = {28'd0, r_int_status};
            c_ADDR_IEN: reg_rdata = {28'd0, r_int_enable};
            default:    reg_rdata = 32'd0;
        endcase
    end

    assign new_command          = (r_state == S_ISSUE);
    assign cmd_argument         = r_cmd_arg;
    assign cmd_index            = r_cmd_idx;
    assign timeout_enable       = r_tmo_en;
    assign no_response          = r_no_resp;
    assign ack_response         = r_ack_resp;
    assign ack_command_complete = r_ack_done;
    assign irq                  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_host_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_host_regs
// Brief    : Self-checking bench for sd_cmd_host_regs (register table + launch
//            scoreboard + handshake sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_host_regs;

    localparam int TMO = 20;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   reg_addr;
    logic         reg_wr;
    logic [31:0]  reg_wdata;
    logic [31:0]  reg_rdata;
    logic         irq;
    logic         new_command;
    logic [31:0]  cmd_argument;
    logic [5:0]   cmd_index;
    logic         timeout_enable;
    logic         no_response;
    logic [127:0] response;
    logic         enable_response;
    logic         ack_response;
    logic         enable_command_complete;
    logic         ack_command_complete;

    sd_cmd_host_regs #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (5)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .reg_addr                (reg_addr),
        .reg_wr                  (reg_wr),
        .reg_wdata               (reg_wdata),
        .reg_rdata               (reg_rdata),
        .irq                     (irq),
        .new_command             (new_command),
        .cmd_argument            (cmd_argument),
        .cmd_index               (cmd_index),
        .timeout_enable          (timeout_enable),
        .no_response             (no_response),
        .response                (response),
        .enable_response         (enable_response),
        .ack_response            (ack_response),
        .enable_command_complete (enable_command_complete),
        .ack_command_complete    (ack_command_complete)
    );

    always #10 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        tmo;
        logic        nr;
    } launch_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    launch_t     launch_q[$];
    logic [31:0] rd_q[$];
    launch_t     mon_l;
    vec_t        tbl[$];

    localparam logic [127:0] RESP_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] RESP_B = 128'h5555AAAA_33331111_22224444_66668888;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        step();
        reg_wr    = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        rd_q.push_back(exp);
        reg_addr = a;
        #1;
        check(name, reg_rdata, rd_q.pop_front());
    endtask

    task automatic push_launch(input logic [5:0] idx, input logic [31:0] arg,
                               input logic tmo, input logic nr);
        launch_t l;
        l.idx = idx; l.arg = arg; l.tmo = tmo; l.nr = nr;
        launch_q.push_back(l);
    endtask

    // Every new_command cycle must match exactly one queued launch.
    always @(negedge clock) begin
        if (new_command === 1'b1) begin
            if (launch_q.size() == 0) begin
                n_checks++;
                $display("FAIL new_command: got unexpected pulse, expected none");
            end else begin
                mon_l = launch_q.pop_front();
                check("launch_index", {26'd0, cmd_index}, {26'd0, mon_l.idx});
                check("launch_arg", cmd_argument, mon_l.arg);
                check("launch_tmo", {31'd0, timeout_enable}, {31'd0, mon_l.tmo});
                check("launch_nr", {31'd0, no_response}, {31'd0, mon_l.nr});
            end
        end
    end

    initial begin
        int busy_cnt;
        bit went_idle;
        bit saw_ack;

        reset = 1'b1; reg_addr = 4'd0; reg_wr = 1'b0; reg_wdata = 32'd0;
        response = 128'd0; enable_response = 1'b0; enable_command_complete = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_new_command", {31'd0, new_command}, 32'd0);
        check("rst_ack_resp", {31'd0, ack_response}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_cmd_index", {26'd0, cmd_index}, 32'd0);

        // Register-bus table: reset values, masking, read-only and unmapped.
        for (int a = 0; a <= 9; a++) tbl.push_back('{1'b0, 4'(a), 32'd0, 32'd0});
        tbl.push_back('{1'b0, 4'd15, 32'd0,          32'd0});
        tbl.push_back('{1'b1, 4'd0,  32'hDEADBEEF,   32'hDEADBEEF});
        tbl.push_back('{1'b1, 4'd8,  32'hFFFFFFFF,   32'h0000000F});
        tbl.push_back('{1'b1, 4'd9,  32'h12345678,   32'd0});
        tbl.push_back('{1'b1, 4'd6,  32'hFFFFFFFF,   32'd0});
        tbl.push_back('{1'b1, 4'd2,  32'hFFFFFFFF,   32'd0});
        tbl.push_back('{1'b1, 4'd7,  32'h0000000F,   32'd0});
        tbl.push_back('{1'b1, 4'd0,  32'h000001AA,   32'h000001AA});
        tbl.push_back('{1'b1, 4'd8,  32'h00000001,   32'h00000001});
        foreach (tbl[i]) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
            rd_chk($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
        end
        check("tbl_irq", {31'd0, irq}, 32'd0);

        // Launch with response, then completion.
        push_launch(6'd8, 32'h1AA, 1'b1, 1'b0);
        wr(4'd1, 32'h0208);
        rd_chk("s1_busy", 4'd6, 32'd1);
        step(); step();
        response = RESP_A;
        enable_response = 1'b1;
        check("s1_ack_before", {31'd0, ack_response}, 32'd0);
        step();
        check("s1_ack_rise", {31'd0, ack_response}, 32'd1);
        step(); step();
        check("s1_ack_hold", {31'd0, ack_response}, 32'd1);
        enable_response = 1'b0;
        response = RESP_B;
        check("s1_ack_still", {31'd0, ack_response}, 32'd1);
        step();
        check("s1_ack_fall", {31'd0, ack_response}, 32'd0);
        rd_chk("s1_int_resp", 4'd7, 32'h2);
        check("s1_irq_masked", {31'd0, irq}, 32'd0);
        enable_command_complete = 1'b1;
        step();
        check("s1_ackcc_rise", {31'd0, ack_command_complete}, 32'd1);
        enable_command_complete = 1'b0;
        step();
        check("s1_ackcc_fall", {31'd0, ack_command_complete}, 32'd0);
        rd_chk("s1_int_done", 4'd7, 32'h3);
        rd_chk("s1_idle", 4'd6, 32'd0);
        check("s1_irq_lag", {31'd0, irq}, 32'd0);
        step();
        check("s1_irq_set", {31'd0, irq}, 32'd1);
        rd_chk("s1_resp0", 4'd2, 32'h76543210);
        rd_chk("s1_resp1", 4'd3, 32'hFEDCBA98);
        rd_chk("s1_resp2", 4'd4, 32'h89ABCDEF);
        rd_chk("s1_resp3", 4'd5, 32'h01234567);
        wr(4'd7, 32'h1);
        check("s1_irq_w1c_lag", {31'd0, irq}, 32'd1);
        rd_chk("s1_int_w1c", 4'd7, 32'h2);
        step();
        check("s1_irq_clear", {31'd0, irq}, 32'd0);
        wr(4'd7, 32'h2);

        // No-response command: spurious response request must be ignored.
        push_launch(6'd0, 32'h1AA, 1'b0, 1'b1);
        wr(4'd1, 32'h0100);
        step();
        response = RESP_B;
        enable_response = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s2_no_ack", {31'd0, ack_response}, 32'd0);
        end
        enable_command_complete = 1'b1;
        step();
        check("s2_ackcc", {31'd0, ack_command_complete}, 32'd1);
        enable_response = 1'b0;
        enable_command_complete = 1'b0;
        step();
        check("s2_ackcc_fall", {31'd0, ack_command_complete}, 32'd0);
        rd_chk("s2_int", 4'd7, 32'h1);
        rd_chk("s2_resp0", 4'd2, 32'h76543210);
        rd_chk("s2_resp3", 4'd5, 32'h01234567);
        wr(4'd7, 32'hF);

        // Watchdog: engine silent.
        push_launch(6'd5, 32'h1AA, 1'b1, 1'b0);
        wr(4'd1, 32'h0205);
        busy_cnt = 0; went_idle = 0; saw_ack = 0;
        for (int i = 0; i < 3 * TMO; i++) begin
            reg_addr = 4'd6;
            #1;
            if (reg_rdata[0] == 1'b0) begin
                went_idle = 1;
                break;
            end
            busy_cnt++;
            if (ack_response || ack_command_complete) saw_ack = 1;
            step();
        end
        check("s3_went_idle", {31'd0, went_idle}, 32'd1);
        check("s3_busy_cycles", busy_cnt, TMO + 1);
        check("s3_no_ack", {31'd0, saw_ack}, 32'd0);
        rd_chk("s3_int", 4'd7, 32'h4);
        wr(4'd7, 32'hF);
        push_launch(6'd17, 32'h1AA, 1'b1, 1'b0);
        wr(4'd1, 32'h0211);
        step();
        rd_chk("s3_relaunch_busy", 4'd6, 32'd1);

        // COMMAND write while busy.
        wr(4'd1, 32'h0203);
        rd_chk("s4_int_err", 4'd7, 32'h8);
        check("s4_cmd_index", {26'd0, cmd_index}, 32'd17);
        rd_chk("s4_cmd_reg", 4'd1, 32'h211);
        enable_command_complete = 1'b1;
        step();
        enable_command_complete = 1'b0;
        step();
        rd_chk("s4_idle", 4'd6, 32'd0);
        wr(4'd7, 32'hF);

        // Reset during a response acknowledge.
        push_launch(6'd2, 32'h1AA, 1'b0, 1'b0);
        wr(4'd1, 32'h0002);
        step();
        enable_response = 1'b1;
        step();
        check("s5_ack_pre", {31'd0, ack_response}, 32'd1);
        reset = 1'b1;
        step();
        check("s5_ack_rst", {31'd0, ack_response}, 32'd0);
        check("s5_cmd_index", {26'd0, cmd_index}, 32'd0);
        rd_chk("s5_state", 4'd6, 32'd0);
        rd_chk("s5_int", 4'd7, 32'd0);
        rd_chk("s5_arg", 4'd0, 32'd0);
        reset = 1'b0;
        enable_response = 1'b0;
        step(); step();
        check("launch_q_empty", launch_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
